int_flag_unit: RTL and testbench

- Flag and interrupt front-end that sits alongside the MCU control unit.
- Holds the C, Z and I flags and the shadow C/Z copies used across interrupt entry and return.
- Synchronises and edge-detects the external interrupt line, holds a pending request, and drives the masked request INT_R into the control unit.
- Its flag outputs feed the control unit's C_FLAG_CONTR/Z_FLAG_CONTR branch inputs.

---
 rtl/int_flag_unit.sv | 124 ++++++++++++
 tb/tb_int_flag_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/int_flag_unit.sv
// Flag and interrupt front-end beside the MCU control unit: C/Z/I flags, shadow copies,
// interrupt-line synchroniser with edge detect, pending request latch and ack counter.
module int_flag_unit #(
    parameter int CNT_W        = 8,
    parameter bit LATCH_MASKED = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             C_IN,
    input  logic             Z_IN,
    input  logic             FLG_C_SET,
    input  logic             FLG_C_CLR,
    input  logic             FLG_C_LD,
    input  logic             FLG_Z_LD,
    input  logic             FLG_LD_SEL,
    input  logic             FLG_SHAD_LD,
    input  logic             I_SET,
    input  logic             I_CLR,
    input  logic             INT_IN,
    input  logic             INT_ACK,
    output logic             C_FLAG,
    output logic             Z_FLAG,
    output logic             I_FLAG,
    output logic             INT_R,
    output logic             OVERRUN,
    output logic [CNT_W-1:0] INT_COUNT
);

    logic             r_c;
    logic             r_z;
    logic             r_i;
    logic             r_shad_c;
    logic             r_shad_z;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             r_pending;
    logic             r_overrun;
    logic [CNT_W-1:0] r_count;

    logic             w_edge;
    logic             w_set_req;
    logic             w_ack_taken;
    logic             w_c_ld_val;
    logic             w_z_ld_val;

    assign w_edge      = r_s2 & ~r_s3;
    assign w_set_req   = w_edge & (r_i | LATCH_MASKED);
    assign w_ack_taken = INT_ACK & r_pending;
    assign w_c_ld_val  = FLG_LD_SEL ? r_shad_c : C_IN;
    assign w_z_ld_val  = FLG_LD_SEL ? r_shad_z : Z_IN;

    // Flags and shadow; the shadow captures pre-edge C/Z even when they change this cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_i      <= 1'b0;
            r_shad_c <= 1'b0;
            r_shad_z <= 1'b0;
        end else begin
            if (FLG_C_CLR)
                r_c <= 1'b0;
            else if (FLG_C_SET)
                r_c <= 1'b1;
            else if (FLG_C_LD)
                r_c <= w_c_ld_val;

            if (FLG_Z_LD)
                r_z <= w_z_ld_val;

            if (FLG_SHAD_LD) begin
                r_shad_c <= r_c;
                r_shad_z <= r_z;
            end

            if (I_CLR)
                r_i <= 1'b0;
            else if (I_SET)
                r_i <= 1'b1;
        end
    end

    // Three-stage synchroniser; the third stage only serves the edge detector.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= INT_IN;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A new request wins over a same-cycle ack so it is never lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_set_req)
                r_pending <= 1'b1;
            else if (INT_ACK)
                r_pending <= 1'b0;

            if (w_set_req && r_pending && !INT_ACK)
                r_overrun <= 1'b1;

            if (w_ack_taken)
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign C_FLAG    = r_c;
    assign Z_FLAG    = r_z;
    assign I_FLAG    = r_i;
    assign INT_R     = r_pending & r_i;
    assign OVERRUN   = r_overrun;
    assign INT_COUNT = r_count;

endmodule

// File: tb/tb_int_flag_unit.sv
// Bench for int_flag_unit: two instances (masked edges latched / discarded) driven in
// parallel, with a cycle model feeding an expected-output queue plus directed spot checks.
module tb_int_flag_unit;

    logic       CLK;
    logic       RESET;
    logic       C_IN, Z_IN;
    logic       FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD;
    logic       I_SET, I_CLR, INT_IN, INT_ACK;

    logic       c0, z0, i0, ir0, ov0;
    logic [7:0] cnt0;
    logic       c1, z1, i1, ir1, ov1;
    logic [7:0] cnt1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       c, z, i;
        logic       ir0, ov0, ir1, ov1;
        logic [7:0] cnt0, cnt1;
    } exp_t;

    exp_t exp_q[$];

    // model state: index 0 = latching instance, 1 = discarding instance
    logic       m_c, m_z, m_i, m_sc, m_sz, m_s1, m_s2, m_s3;
    logic       m_pend[2];
    logic       m_ov[2];
    logic [7:0] m_cnt[2];

    int_flag_unit #(.CNT_W(8), .LATCH_MASKED(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .C_IN(C_IN), .Z_IN(Z_IN),
        .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
        .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET(I_SET), .I_CLR(I_CLR), .INT_IN(INT_IN), .INT_ACK(INT_ACK),
        .C_FLAG(c0), .Z_FLAG(z0), .I_FLAG(i0), .INT_R(ir0), .OVERRUN(ov0), .INT_COUNT(cnt0)
    );

    int_flag_unit #(.CNT_W(8), .LATCH_MASKED(1'b0)) dut_nl (
        .CLK(CLK), .RESET(RESET), .C_IN(C_IN), .Z_IN(Z_IN),
        .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
        .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET(I_SET), .I_CLR(I_CLR), .INT_IN(INT_IN), .INT_ACK(INT_ACK),
        .C_FLAG(c1), .Z_FLAG(z1), .I_FLAG(i1), .INT_R(ir1), .OVERRUN(ov1), .INT_COUNT(cnt1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic clear_ctl();
        C_IN = 0; Z_IN = 0;
        FLG_C_SET = 0; FLG_C_CLR = 0; FLG_C_LD = 0; FLG_Z_LD = 0;
        FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic n_c, n_z, n_i, n_sc, n_sz, edge_d, set_r;
        if (RESET) begin
            m_c = 0; m_z = 0; m_i = 0; m_sc = 0; m_sz = 0;
            m_s1 = 0; m_s2 = 0; m_s3 = 0;
            for (int j = 0; j < 2; j++) begin
                m_pend[j] = 0; m_ov[j] = 0; m_cnt[j] = 8'd0;
            end
        end else begin
            edge_d = m_s2 && !m_s3;
            for (int j = 0; j < 2; j++) begin
                set_r = edge_d && (m_i || (j == 0));
                if (INT_ACK && m_pend[j]) m_cnt[j] = m_cnt[j] + 8'd1;
                if (set_r && m_pend[j] && !INT_ACK) m_ov[j] = 1;
                if (set_r) m_pend[j] = 1;
                else if (INT_ACK) m_pend[j] = 0;
            end
            n_c  = FLG_C_CLR ? 1'b0 : FLG_C_SET ? 1'b1 :
                   FLG_C_LD ? (FLG_LD_SEL ? m_sc : C_IN) : m_c;
            n_z  = FLG_Z_LD ? (FLG_LD_SEL ? m_sz : Z_IN) : m_z;
            n_sc = FLG_SHAD_LD ? m_c : m_sc;
            n_sz = FLG_SHAD_LD ? m_z : m_sz;
            n_i  = I_CLR ? 1'b0 : I_SET ? 1'b1 : m_i;
            m_c = n_c; m_z = n_z; m_sc = n_sc; m_sz = n_sz; m_i = n_i;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = INT_IN;
        end
    endtask

    task automatic tick();
        exp_t e, g;
        model_step();
        e.c = m_c; e.z = m_z; e.i = m_i;
        e.ir0 = m_pend[0] & m_i; e.ov0 = m_ov[0]; e.cnt0 = m_cnt[0];
        e.ir1 = m_pend[1] & m_i; e.ov1 = m_ov[1]; e.cnt1 = m_cnt[1];
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        g = exp_q.pop_front();
        if (c0 !== g.c || z0 !== g.z || i0 !== g.i || ir0 !== g.ir0 || ov0 !== g.ov0 ||
            cnt0 !== g.cnt0 || c1 !== g.c || z1 !== g.z || i1 !== g.i || ir1 !== g.ir1 ||
            ov1 !== g.ov1 || cnt1 !== g.cnt1) begin
            check("sb_lm1", {16'd0, c0, z0, i0, ir0, ov0, 3'd0, cnt0},
                  {16'd0, g.c, g.z, g.i, g.ir0, g.ov0, 3'd0, g.cnt0});
            check("sb_lm0", {16'd0, c1, z1, i1, ir1, ov1, 3'd0, cnt1},
                  {16'd0, g.c, g.z, g.i, g.ir1, g.ov1, 3'd0, g.cnt1});
        end else begin
            check("sb", 32'(cnt0), 32'(g.cnt0));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // One 1-cycle-high pulse, pending set, then acked: one count per call.
    task automatic ack_round();
        INT_IN = 1; tick();
        INT_IN = 0; ticks(2);
        INT_ACK = 1; tick();
        INT_ACK = 0;
    endtask

    initial begin
        clear_ctl();
        INT_IN = 0;
        RESET = 1;
        ticks(2);
        check("rst_c", 32'(c0), 0);
        check("rst_cnt", 32'(cnt0), 0);
        RESET = 0;
        tick();

        FLG_C_SET = 1; FLG_C_CLR = 1; tick(); clear_ctl();
        check("c_clr_wins", 32'(c0), 0);
        FLG_C_SET = 1; tick(); clear_ctl();
        check("c_set", 32'(c0), 1);
        FLG_C_LD = 1; C_IN = 0; tick(); clear_ctl();
        check("c_ld_alu", 32'(c0), 0);

        FLG_C_SET = 1; FLG_Z_LD = 1; Z_IN = 1; tick(); clear_ctl();
        FLG_SHAD_LD = 1; FLG_C_CLR = 1; FLG_Z_LD = 1; Z_IN = 0; tick(); clear_ctl();
        check("shad_c_now", 32'(c0), 0);
        check("shad_z_now", 32'(z0), 0);
        FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1; C_IN = 0; Z_IN = 0; tick(); clear_ctl();
        check("ld_shad_c", 32'(c0), 1);
        check("ld_shad_z", 32'(z0), 1);

        I_SET = 1; tick(); clear_ctl();
        INT_IN = 1; tick();
        tick();
        check("intr_lat2", 32'(ir0), 0);
        tick();
        check("intr_lat3", 32'(ir0), 1);
        ticks(7);
        INT_IN = 0; ticks(2);
        check("long_pulse_ov", 32'(ov0), 0);
        INT_ACK = 1; tick(); clear_ctl();
        check("ack_intr", 32'(ir0), 0);
        check("ack_cnt", 32'(cnt0), 1);
        ticks(2);

        I_CLR = 1; tick(); clear_ctl();
        INT_IN = 1; ticks(4);
        INT_IN = 0; ticks(3);
        check("masked_intr", 32'(ir0), 0);
        I_SET = 1; tick(); clear_ctl();
        check("lm1_after_iset", 32'(ir0), 1);
        check("lm0_after_iset", 32'(ir1), 0);

        INT_IN = 1; ticks(2);
        INT_IN = 0; ticks(3);
        check("overrun", 32'(ov0), 1);
        check("overrun_lm0", 32'(ov1), 0);
        INT_IN = 1; tick();
        INT_IN = 0; tick();
        INT_ACK = 1; tick(); clear_ctl();
        check("ack_edge_pend", 32'(ir0), 1);
        check("ack_edge_cnt", 32'(cnt0), 2);
        INT_ACK = 1; tick(); clear_ctl();
        ticks(2);

        while (m_cnt[0] != 8'd255) ack_round();
        check("cnt_255", 32'(cnt0), 255);
        ack_round();
        check("cnt_wrap", 32'(cnt0), 0);

        for (int k = 0; k < 5; k++) ack_round();
        INT_IN = 1; ticks(3);
        check("pre_rst_intr", 32'(ir0), 1);
        check("pre_rst_cnt", 32'(cnt0), 5);
        RESET = 1; tick();
        check("rst_intr", 32'(ir0), 0);
        check("rst_i", 32'(i0), 0);
        check("rst_cnt5", 32'(cnt0), 0);
        check("rst_ov", 32'(ov0), 0);
        RESET = 0; ticks(3);
        check("post_rst_intr", 32'(ir0), 0);
        I_SET = 1; tick(); clear_ctl();
        check("post_rst_pend", 32'(ir0), 1);
        check("post_rst_lm0", 32'(ir1), 0);
        INT_IN = 0; ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
